// File: rtl/sram_pkg.sv
// Shared types and build options for param_sync_sram.
// Defining SRAM_OUT_REG_EN adds an output register stage (read latency 2).
package sram_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

`ifdef SRAM_OUT_REG_EN
  localparam int SRAM_LAT = 2;
`else
  localparam int SRAM_LAT = 1;
`endif

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/sram_array.sv
// Pure storage for param_sync_sram: DEPTH x DATA_W words, one synchronous
// port with per-byte write enables and a registered, read-first read.
module sram_array
  import sram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int BE_W   = be_width(DATA_W)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[addr];
  end

  // NOTE: the array and its read register carry no reset; a reset on a
  // memory array prevents RAM inference. The top-level INIT sweep clears
  // the contents and masks the read register until a real read lands.
  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end

  // NOTE: non-blocking writes are what make a same-cycle read return the
  // old word (read-first); a blocking write here would leak the new data.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/param_sync_sram.sv
// Parametrised single-port SRAM with post-reset clear sweep, read-valid,
// out-of-range detection. SRAM_OUT_REG_EN adds one output pipeline stage.
module param_sync_sram
  import sram_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int ADDR_W = 8,
  parameter  int DEPTH  = 256,
  localparam int BE_W   = be_width(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              we,
  input  logic              rd,
  input  logic [BE_W-1:0]   be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              busy,
  output logic              addr_err
);

  if (DATA_W % 8 != 0) begin : g_bad_data_w
    $error("param_sync_sram: DATA_W must be a multiple of 8");
  end
  if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
    $error("param_sync_sram: DEPTH must be in 1..2**ADDR_W");
  end

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              busy_q, busy_d;

  logic              accept;
  logic              wr_req;
  logic              rd_req;
  logic              addr_oor;

  logic              arr_we;
  logic [BE_W-1:0]   arr_be;
  logic              arr_re;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;

  // First output stage: valid, error, and whether data comes from the array.
  logic              s1_valid_q, s1_valid_d;
  logic              s1_err_q, s1_err_d;
  logic              s1_sel_q, s1_sel_d;
  logic [DATA_W-1:0] s1_data;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    busy_d    = busy_q;
    case (state_q)
      INIT: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = RUN;
          clr_cnt_d = '0;
          busy_d    = 1'b0;
        end
      end
      RUN: begin
        busy_d = 1'b0;
      end
      default: begin
        state_d   = INIT;
        clr_cnt_d = '0;
        busy_d    = 1'b1;
      end
    endcase
  end

  always_comb begin
    accept   = cs && (state_q == RUN);
    wr_req   = accept && we;
    rd_req   = accept && rd;
    addr_oor = ({1'b0, addr} >= DEPTH_L);
  end

  // During INIT the array port is owned by the clear sweep.
  always_comb begin
    if (state_q == INIT) begin
      arr_we    = 1'b1;
      arr_be    = '1;
      arr_re    = 1'b0;
      arr_addr  = clr_cnt_q;
      arr_wdata = '0;
    end else begin
      arr_we    = wr_req && !addr_oor;
      arr_be    = be;
      arr_re    = rd_req && !addr_oor;
      arr_addr  = addr;
      arr_wdata = data_in;
    end
  end

  always_comb begin
    s1_valid_d = rd_req;
    s1_err_d   = (wr_req || rd_req) && addr_oor;
    s1_sel_d   = s1_sel_q;
    if (rd_req) s1_sel_d = !addr_oor;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT;
      clr_cnt_q  <= '0;
      busy_q     <= 1'b1;
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_sel_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      busy_q     <= busy_d;
      s1_valid_q <= s1_valid_d;
      s1_err_q   <= s1_err_d;
      s1_sel_q   <= s1_sel_d;
    end
  end

  sram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .BE_W   (BE_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .be    (arr_be),
    .re    (arr_re),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  // Zero after reset or an out-of-range read; otherwise the last array read.
  assign s1_data = s1_sel_q ? arr_rdata : '0;
  assign busy    = busy_q;

`ifdef SRAM_OUT_REG_EN
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_err_q, out_err_d;

  always_comb begin
    out_valid_d = s1_valid_q;
    out_err_d   = s1_err_q;
    out_data_d  = out_data_q;
    if (s1_valid_q) out_data_d = s1_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
    end
  end

  assign data_out = out_data_q;
  assign rd_valid = out_valid_q;
  assign addr_err = out_err_q;
`else
  assign data_out = s1_data;
  assign rd_valid = s1_valid_q;
  assign addr_err = s1_err_q;
`endif

endmodule

// File: tb/tb_param_sync_sram.sv
// Directed self-checking bench for param_sync_sram: an 8x256 instance and a
// 32x200 instance share clock and reset.
module tb_param_sync_sram;
  import sram_pkg::*;

  localparam int LAT = SRAM_LAT;

  logic clk;
  logic rst_n;

  logic        a_cs, a_we, a_rd;
  logic [0:0]  a_be;
  logic [7:0]  a_addr, a_din, a_dout;
  logic        a_rd_valid, a_busy, a_addr_err;

  logic        b_cs, b_we, b_rd;
  logic [3:0]  b_be;
  logic [7:0]  b_addr;
  logic [31:0] b_din, b_dout;
  logic        b_rd_valid, b_busy, b_addr_err;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] burst_exp [5] = '{8'h00, 8'h01, 8'h10, 8'h06, 8'h00};

  param_sync_sram #(.DATA_W(8), .ADDR_W(8), .DEPTH(256)) u_dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs       (a_cs),
    .we       (a_we),
    .rd       (a_rd),
    .be       (a_be),
    .addr     (a_addr),
    .data_in  (a_din),
    .data_out (a_dout),
    .rd_valid (a_rd_valid),
    .busy     (a_busy),
    .addr_err (a_addr_err)
  );

  param_sync_sram #(.DATA_W(32), .ADDR_W(8), .DEPTH(200)) u_dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs       (b_cs),
    .we       (b_we),
    .rd       (b_rd),
    .be       (b_be),
    .addr     (b_addr),
    .data_in  (b_din),
    .data_out (b_dout),
    .rd_valid (b_rd_valid),
    .busy     (b_busy),
    .addr_err (b_addr_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion by 200000ns, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Counts edges from reset release until each busy falls; drops a-side
  // requests the moment a leaves INIT.
  task automatic init_sweep(output int fa, output int fb, output logic seen);
    int n;
    n = 0; fa = 0; fb = 0; seen = 1'b0;
    while ((fa == 0 || fb == 0) && n < 1000) begin
      @(posedge clk); #1;
      n++;
      if (a_rd_valid || a_addr_err) seen = 1'b1;
      if (!a_busy && fa == 0) begin
        fa = n; a_cs = 1'b0; a_we = 1'b0; a_rd = 1'b0;
      end
      if (!b_busy && fb == 0) fb = n;
    end
  endtask

  task automatic wr_a(input logic [7:0] ad, input logic [7:0] d);
    @(negedge clk);
    a_cs = 1'b1; a_we = 1'b1; a_rd = 1'b0; a_addr = ad; a_din = d;
    @(posedge clk); #1;
    a_cs = 1'b0; a_we = 1'b0;
  endtask

  task automatic rd_a(input string tag, input logic [7:0] ad, input logic [7:0] exp);
    @(negedge clk);
    a_cs = 1'b1; a_rd = 1'b1; a_we = 1'b0; a_addr = ad;
    @(posedge clk); #1;
    a_cs = 1'b0; a_rd = 1'b0;
    repeat (LAT - 1) begin @(posedge clk); #1; end
    check(tag, a_dout, exp);
    check({tag, "_valid"}, a_rd_valid, 1);
  endtask

  task automatic wr_b(input string tag, input logic [7:0] ad, input logic [31:0] d,
                      input logic [3:0] bev, input logic exp_err);
    @(negedge clk);
    b_cs = 1'b1; b_we = 1'b1; b_rd = 1'b0; b_addr = ad; b_din = d; b_be = bev;
    @(posedge clk); #1;
    b_cs = 1'b0; b_we = 1'b0;
    repeat (LAT - 1) begin @(posedge clk); #1; end
    check({tag, "_err"}, b_addr_err, exp_err);
  endtask

  task automatic rd_b(input string tag, input logic [7:0] ad, input logic [31:0] exp,
                      input logic exp_err);
    @(negedge clk);
    b_cs = 1'b1; b_rd = 1'b1; b_we = 1'b0; b_addr = ad;
    @(posedge clk); #1;
    b_cs = 1'b0; b_rd = 1'b0;
    repeat (LAT - 1) begin @(posedge clk); #1; end
    check(tag, b_dout, exp);
    check({tag, "_valid"}, b_rd_valid, 1);
    check({tag, "_err"}, b_addr_err, exp_err);
  endtask

  initial begin
    int   fa, fb;
    logic seen;

    a_cs = 0; a_we = 0; a_rd = 0; a_be = 1'b1; a_addr = 0; a_din = 0;
    b_cs = 0; b_we = 0; b_rd = 0; b_be = 0;    b_addr = 0; b_din = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_busy",     a_busy, 1);
    check("rst_data",     a_dout, 0);
    check("rst_valid",    a_rd_valid, 0);
    check("rst_addr_err", a_addr_err, 0);
    check("rst_busy_b",   b_busy, 1);

    // Requests held active through INIT must be ignored.
    a_cs = 1'b1; a_we = 1'b1; a_rd = 1'b1; a_addr = 8'h00; a_din = 8'h5A;
    @(negedge clk); rst_n = 1'b1;
    init_sweep(fa, fb, seen);
    check("init_len_a", fa, 256);
    check("init_len_b", fb, 200);
    check("init_ignored", seen, 0);
    rd_a("sweep_lo", 8'h00, 8'h00);
    rd_a("sweep_hi", 8'hFF, 8'h00);

    // Write/read with a back-to-back read burst.
    wr_a(8'd0, 8'h00);
    wr_a(8'd1, 8'h01);
    wr_a(8'd2, 8'h10);
    wr_a(8'd3, 8'h06);
    for (int i = 0; i < 5 + LAT - 1; i++) begin
      @(negedge clk);
      if (i < 5) begin
        a_cs = 1'b1; a_rd = 1'b1; a_addr = 8'(i);
      end else begin
        a_cs = 1'b0; a_rd = 1'b0;
      end
      @(posedge clk); #1;
      if (i >= LAT - 1) begin
        check("burst_valid", a_rd_valid, 1);
        check("burst_data", a_dout, burst_exp[i-LAT+1]);
      end
    end
    @(negedge clk); a_cs = 1'b0; a_rd = 1'b0;
    @(posedge clk); #1;
    check("burst_valid_drop", a_rd_valid, 0);

    // Read-first on a simultaneous write and read.
    wr_a(8'd5, 8'h33);
    @(negedge clk);
    a_cs = 1'b1; a_we = 1'b1; a_rd = 1'b1; a_addr = 8'd5; a_din = 8'h77;
    @(posedge clk); #1;
    a_cs = 1'b0; a_we = 1'b0; a_rd = 1'b0;
    repeat (LAT - 1) begin @(posedge clk); #1; end
    check("rf_old", a_dout, 8'h33);
    check("rf_old_valid", a_rd_valid, 1);
    rd_a("rf_new", 8'd5, 8'h77);
    repeat (3) @(posedge clk);
    #1;
    check("hold_data", a_dout, 8'h77);
    check("hold_valid", a_rd_valid, 0);
    wr_a(8'd5, 8'h99);
    check("hold_after_wr", a_dout, 8'h77);

    // Byte enables on the 32-bit instance.
    wr_b("be_full", 8'd3, 32'hAABBCCDD, 4'hF, 1'b0);
    wr_b("be_part", 8'd3, 32'h11223344, 4'b0101, 1'b0);
    rd_b("be_merge", 8'd3, 32'hAA22CC44, 1'b0);
    wr_b("be_none", 8'd3, 32'hFFFFFFFF, 4'h0, 1'b0);
    rd_b("be_noop", 8'd3, 32'hAA22CC44, 1'b0);
    wr_b("last_wr", 8'd199, 32'h01020304, 4'hF, 1'b0);
    rd_b("last_rd", 8'd199, 32'h01020304, 1'b0);

    // Out-of-range accesses on the DEPTH=200 instance.
    wr_b("oor_wr", 8'hD0, 32'hDEADBEEF, 4'hF, 1'b1);
    @(posedge clk); #1;
    check("oor_wr_pulse", b_addr_err, 0);
    rd_b("oor_rd", 8'hD0, 32'h0, 1'b1);
    @(posedge clk); #1;
    check("oor_rd_pulse", b_addr_err, 0);
    check("oor_rd_hold", b_dout, 32'h0);
    rd_b("oor_alias8", 8'd8, 32'h0, 1'b0);
    rd_b("oor_last", 8'd199, 32'h01020304, 1'b0);
    rd_b("oor_keep3", 8'd3, 32'hAA22CC44, 1'b0);

    // Reset during a read burst.
    @(negedge clk);
    a_cs = 1'b1; a_rd = 1'b1; a_addr = 8'd1;
    repeat (LAT) begin @(posedge clk); #1; end
    check("mr_pending_valid", a_rd_valid, 1);
    check("mr_pending_data", a_dout, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    check("mr_valid", a_rd_valid, 0);
    check("mr_data", a_dout, 0);
    check("mr_busy", a_busy, 1);
    check("mr_busy_b", b_busy, 1);
    a_cs = 1'b0; a_rd = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    init_sweep(fa, fb, seen);
    check("mr_init_len_a", fa, 256);
    check("mr_init_len_b", fb, 200);

    // Reset in the middle of INIT restarts the full sweep.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mi_busy", a_busy, 1);
    @(negedge clk); rst_n = 1'b1;
    init_sweep(fa, fb, seen);
    check("mi_init_len_a", fa, 256);
    check("mi_init_len_b", fb, 200);
    rd_a("post_clear_a", 8'd1, 8'h00);
    rd_b("post_clear_b", 8'd3, 32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/param_sync_sram.md
# param_sync_sram

Parametrised single-port synchronous SRAM. It is the successor to the fixed 8x256 SRAM and adds configurable width and depth, byte-write enables, a self-clearing initialisation sequence after reset, a read-valid handshake and out-of-range detection. It is intended as the scratch/buffer memory behind bus-side controllers in the design.

## Interface
- `DATA_W`, default 8: word width in bits; must be a multiple of 8.
- `ADDR_W`, default 8: address width.
- `DEPTH`, default 256: number of words; must satisfy 1 ≤ DEPTH ≤ 2**ADDR_W.
- `BE_W`, derived as DATA_W/8: number of byte enables.
- `clk`  in  1  system clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cs`  in  1  chip select; requests are ignored when low.
- `we`  in  1  write request, qualified by `cs`.
- `rd`  in  1  read request, qualified by `cs`.
- `be`  in  BE_W  byte enables for writes; bit i covers data bits [8i+7:8i].
- `addr`  in  ADDR_W  word address.
- `data_in`  in  DATA_W  write data.
- `data_out`  out  DATA_W  registered read data.
- `rd_valid`  out  1  one-cycle pulse when `data_out` carries fresh read data.
- `busy`  out  1  high while initialisation is in progress; requests are ignored.
- `addr_err`  out  1  one-cycle pulse when an accepted request has addr ≥ DEPTH.

## Operation
- The FSM has two states, INIT and RUN. Reset forces INIT with the clear counter at 0.
- INIT:
  - Writes 0 to location `clr_cnt` each cycle and increments the counter.
  - After writing DEPTH-1, moves to RUN.
  - `busy`=1 for the whole state; `cs`, `we` and `rd` are ignored.
- RUN:
  - A request is accepted when `cs`=1 and `busy`=0.
  - Write: `cs`&`we` writes the bytes with `be[i]`=1. Bytes with `be[i]`=0 are unchanged. `be`=0 is a legal no-op write.
  - Read: `cs`&`rd` loads mem[addr] into the output and pulses `rd_valid`.
- Simultaneous `we`&`rd` to the same address is read-first: `data_out` returns the old word, and the new data is visible from the next read.
- Out of range (addr ≥ DEPTH, only possible when DEPTH < 2**ADDR_W):
  - A write is dropped.
  - A read returns 0 with `rd_valid`=1.
  - `addr_err` pulses in the same cycle as `rd_valid` would.
- Between reads, `data_out` holds its last value.
- Reset values: `data_out`=0, `rd_valid`=0, `addr_err`=0, `busy`=1 (it is the INIT indicator).
- Asserting `rst_n` mid-INIT or mid-RUN aborts everything. The clear restarts from address 0 and any pending `rd_valid` is discarded. Array contents are not reset asynchronously; the INIT sweep clears them.

## Timing
- INIT lasts exactly DEPTH cycles after the first rising edge with `rst_n`=1. `busy` falls on edge DEPTH, and the first request is accepted on edge DEPTH+1.
- Write latency: the write completes on the accepting edge, and a read on the next edge returns the new data.
- Read latency without the macro: 1. `data_out` and `rd_valid` update on the accepting edge.
- Back-to-back reads are allowed every cycle, giving full throughput.
- `addr_err` is aligned with the read-data timing. For writes it pulses one cycle after acceptance.

## Configuration
- `SRAM_OUT_REG_EN` defined:
  - Adds one output pipeline register, so read latency is 2.
  - `data_out`, `rd_valid` and `addr_err` are all delayed together.
  - Throughput is still one read per cycle.
  - Read-first semantics are unchanged.
- Not defined: latency 1 as above.

## Structure
- Package `sram_pkg`:
  - state enum {INIT, RUN};
  - `SRAM_LAT` localparam (1 or 2, selected by the macro);
  - a function computing BE_W from DATA_W.
- Sub-module `sram_array`:
  - pure storage, DEPTH x DATA_W;
  - one synchronous port with per-byte write enable and registered read;
  - no reset.
- The top level holds the FSM, clear counter, range check and optional output stage.
- Elaboration-time checks: DATA_W%8==0 and DEPTH ≤ 2**ADDR_W.

## Test plan
- **Reset sweep:** DEPTH=256; release `rst_n` → `busy` stays high for exactly 256 cycles; reads of addr 0x00 and 0xFF then return 0.
- **Write/read:** write 0x00,0x01,0x10,0x06 to addr 0–3, then read addr 0–4 → 0x00,0x01,0x10,0x06,0x00; each has `rd_valid` at latency 1 (2 with macro).
- **Byte enables:** DATA_W=32; write 0xAABBCCDD with be=4'hF, then 0x11223344 with be=4'b0101 → read returns 0xAA22CC44.
- **Read-first:** addr 5 holds 0x33; same-cycle write 0x77 and read of addr 5 → returns 0x33; the next read returns 0x77.
- **Out of range:** DEPTH=200, ADDR_W=8; write to 0xD0, then read 0xD0 → `data_out`=0, `addr_err` pulses for 1 cycle, and locations 0–199 are unchanged.
- **Reset mid-operation:** drop `rst_n` during a read burst and mid-INIT → outputs return to reset values immediately and INIT restarts for a full DEPTH cycles.
